// File: rtl/isa_pkg.sv
// ISA constants shared by the decode stage: opcodes, R-type functs, ALU op
// encoding and the ID/EX control bundle.
package isa_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_SLT   = 6'b101010;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd4
    } alu_op_e;

    typedef struct packed {
        logic [4:0] dst;
        alu_op_e    alu_op;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       alu_src_imm;
    } ctrl_t;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/reg_file.sv
// 32x32 register file: two combinational read ports with write-through
// bypass, one write port, register k reset to value k, $0 hardwired to zero.
module reg_file (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  i_rs_addr,
    input  logic [4:0]  i_rt_addr,
    output logic [31:0] o_rs_data,
    output logic [31:0] o_rt_data,
    input  logic        i_wb_en,
    input  logic [4:0]  i_wb_addr,
    input  logic [31:0] i_wb_data
);

    logic [31:0] r_regs [32];
    logic        w_rs_hit;
    logic        w_rt_hit;

    // Reset loads the index pattern; reset wins over a concurrent write-back.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 32; k++) r_regs[k] <= 32'(k);
        end else if (i_wb_en && i_wb_addr != 5'd0) begin
            r_regs[i_wb_addr] <= i_wb_data;
        end
    end

    // A write landing this edge is visible to this cycle's reads.
    assign w_rs_hit  = i_wb_en && (i_wb_addr == i_rs_addr);
    assign w_rt_hit  = i_wb_en && (i_wb_addr == i_rt_addr);
    assign o_rs_data = (i_rs_addr == 5'd0) ? 32'd0 :
                       (w_rs_hit ? i_wb_data : r_regs[i_rs_addr]);
    assign o_rt_data = (i_rt_addr == 5'd0) ? 32'd0 :
                       (w_rt_hit ? i_wb_data : r_regs[i_rt_addr]);

endmodule

// File: rtl/instruction_decode.sv
// Decode stage: control decode, beq/j resolution and the ID/EX register.
module instruction_decode
    import isa_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] IR,
    input  logic [31:0] PC,
    input  logic        wb_en,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    output logic        jump,
    output logic [31:0] jump_addr,
    output logic        branch,
    output logic [31:0] branch_addr,
    output logic [31:0] ex_rs_data,
    output logic [31:0] ex_rt_data,
    output logic [31:0] ex_imm,
    output logic [4:0]  ex_dst,
    output logic [2:0]  ex_alu_op,
    output logic        ex_reg_write,
    output logic        ex_mem_read,
    output logic        ex_mem_write,
    output logic        ex_alu_src_imm
);

    logic [5:0]  w_op;
    logic [5:0]  w_funct;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic [31:0] w_imm;
    logic [31:0] w_rs_data;
    logic [31:0] w_rt_data;
    ctrl_t       w_ctrl;

    logic [31:0] r_rs_data;
    logic [31:0] r_rt_data;
    logic [31:0] r_imm;
    ctrl_t       r_ctrl;

    assign w_op    = IR[31:26];
    assign w_rs    = IR[25:21];
    assign w_rt    = IR[20:16];
    assign w_rd    = IR[15:11];
    assign w_funct = IR[5:0];
    assign w_imm   = sext16(IR[15:0]);

    reg_file u_rf (
        .clk       (clk),
        .rst       (rst),
        .i_rs_addr (w_rs),
        .i_rt_addr (w_rt),
        .o_rs_data (w_rs_data),
        .o_rt_data (w_rt_data),
        .i_wb_en   (wb_en),
        .i_wb_addr (wb_addr),
        .i_wb_data (wb_data)
    );

    // Control decode; anything unrecognised (including beq/j) stays a NOP.
    always_comb begin
        w_ctrl = '0;
        unique case (w_op)
            OP_RTYPE: begin
                w_ctrl.dst       = w_rd;
                w_ctrl.reg_write = 1'b1;
                unique case (w_funct)
                    FN_ADD:  w_ctrl.alu_op = ALU_ADD;
                    FN_SUB:  w_ctrl.alu_op = ALU_SUB;
                    FN_AND:  w_ctrl.alu_op = ALU_AND;
                    FN_OR:   w_ctrl.alu_op = ALU_OR;
                    FN_SLT:  w_ctrl.alu_op = ALU_SLT;
                    default: w_ctrl = '0;
                endcase
            end
            OP_LW: begin
                w_ctrl.dst         = w_rt;
                w_ctrl.alu_op      = ALU_ADD;
                w_ctrl.alu_src_imm = 1'b1;
                w_ctrl.mem_read    = 1'b1;
                w_ctrl.reg_write   = 1'b1;
            end
            OP_SW: begin
                w_ctrl.alu_op      = ALU_ADD;
                w_ctrl.alu_src_imm = 1'b1;
                w_ctrl.mem_write   = 1'b1;
            end
            default: w_ctrl = '0;
        endcase
    end

    // Control transfers resolve here; both are held low during reset.
    assign jump        = !rst && (w_op == OP_J);
    assign branch      = !rst && (w_op == OP_BEQ) && (w_rs_data == w_rt_data);
    assign jump_addr   = {PC[31:28], IR[25:0], 2'b00};
    assign branch_addr = PC + {w_imm[29:0], 2'b00};

    // ID/EX pipeline register, loaded every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rs_data <= '0;
            r_rt_data <= '0;
            r_imm     <= '0;
            r_ctrl    <= '0;
        end else begin
            r_rs_data <= w_rs_data;
            r_rt_data <= w_rt_data;
            r_imm     <= w_imm;
            r_ctrl    <= w_ctrl;
        end
    end

    assign ex_rs_data     = r_rs_data;
    assign ex_rt_data     = r_rt_data;
    assign ex_imm         = r_imm;
    assign ex_dst         = r_ctrl.dst;
    assign ex_alu_op      = r_ctrl.alu_op;
    assign ex_reg_write   = r_ctrl.reg_write;
    assign ex_mem_read    = r_ctrl.mem_read;
    assign ex_mem_write   = r_ctrl.mem_write;
    assign ex_alu_src_imm = r_ctrl.alu_src_imm;

endmodule

// File: tb/tb_instruction_decode.sv
// Bench for instruction_decode: expected ID/EX contents are queued when an
// instruction is driven and compared one edge later; branch/jump checked live.
module tb_instruction_decode;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] IR, PC;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        jump, branch;
    logic [31:0] jump_addr, branch_addr;
    logic [31:0] ex_rs_data, ex_rt_data, ex_imm;
    logic [4:0]  ex_dst;
    logic [2:0]  ex_alu_op;
    logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src_imm;

    always #5 clk = ~clk;

    instruction_decode dut (
        .clk(clk), .rst(rst), .IR(IR), .PC(PC),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .jump(jump), .jump_addr(jump_addr), .branch(branch), .branch_addr(branch_addr),
        .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
        .ex_dst(ex_dst), .ex_alu_op(ex_alu_op), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_alu_src_imm(ex_alu_src_imm)
    );

    typedef struct {
        logic [31:0] rs, rt, imm;
        logic [4:0]  dst;
        logic [2:0]  alu;
        logic        rw, mr, mw, src;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
        return {6'b000000, rs, rt, rd, 5'd0, fn};
    endfunction
    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction
    function automatic exp_t mk(input logic [31:0] rs, rt, imm, input logic [4:0] dst,
                                input logic [2:0] alu, input logic rw, mr, mw, src);
        exp_t e;
        e.rs = rs; e.rt = rt; e.imm = imm; e.dst = dst; e.alu = alu;
        e.rw = rw; e.mr = mr; e.mw = mw; e.src = src;
        return e;
    endfunction
    function automatic logic [31:0] sx(input logic [31:0] ir);
        return {{16{ir[15]}}, ir[15:0]};
    endfunction

    // Drive one cycle's inputs away from the active edge and queue its result.
    task automatic drive(input logic r, input logic [31:0] ir, pc, input logic we,
                         input logic [4:0] wa, input logic [31:0] wd, input exp_t e);
        @(negedge clk);
        rst = r; IR = ir; PC = pc; wb_en = we; wb_addr = wa; wb_data = wd;
        sb.push_back(e);
        #1;
    endtask

    // Advance one edge and compare the ID/EX register against the queue head.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check("ex_rs_data", ex_rs_data, e.rs);
            check("ex_rt_data", ex_rt_data, e.rt);
            check("ex_imm", ex_imm, e.imm);
            check("ex_dst", 32'(ex_dst), 32'(e.dst));
            check("ex_alu_op", 32'(ex_alu_op), 32'(e.alu));
            check("ex_ctrl", {28'd0, ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src_imm},
                  {28'd0, e.rw, e.mr, e.mw, e.src});
        end
    endtask

    localparam exp_t ZERO = '{32'd0, 32'd0, 32'd0, 5'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0};

    initial begin
        logic [31:0] ir;
        rst = 1'b1; IR = '0; PC = '0; wb_en = 1'b0; wb_addr = '0; wb_data = '0;

        // Reset with a live instruction and a competing write to $5.
        drive(1'b1, enc_r(5'd2, 5'd3, 5'd1, 6'b100000), 32'h0, 1'b1, 5'd5, 32'hDEAD, ZERO);
        tick();
        drive(1'b1, {6'b000010, 26'd23}, 32'h104, 1'b0, 5'd0, 32'd0, ZERO);
        check("jump_in_rst", 32'(jump), 32'd0);
        tick();

        // Read back every register: ex_rs_data = k, ex_rt_data = 0.
        for (int k = 0; k < 32; k++) begin
            ir = enc_r(5'(k), 5'd0, 5'd1, 6'b100000);
            drive(1'b0, ir, 32'h0, 1'b0, 5'd0, 32'd0, mk(32'(k), 0, sx(ir), 5'd1, 3'd0, 1, 0, 0, 0));
            tick();
        end

        // reg9 <= 2, then beq $9,$2,+51 at PC 0x44 is taken to 0x110.
        drive(1'b0, 32'd0, 32'h0, 1'b1, 5'd9, 32'd2, ZERO);
        tick();
        ir = enc_i(6'b000100, 5'd9, 5'd2, 16'd51);
        drive(1'b0, ir, 32'h44, 1'b0, 5'd0, 32'd0, mk(2, 2, 51, 0, 0, 0, 0, 0, 0));
        check("beq_taken", 32'(branch), 32'd1);
        check("beq_addr", branch_addr, 32'h110);
        check("beq_nojump", 32'(jump), 32'd0);
        tick();
        // Same beq, reg9 becomes 3 via bypass in this cycle: not taken.
        drive(1'b0, ir, 32'h44, 1'b1, 5'd9, 32'd3, mk(3, 2, 51, 0, 0, 0, 0, 0, 0));
        check("beq_not_taken", 32'(branch), 32'd0);
        tick();

        // Negative offset with wrap: 0xFFEA -> PC-88.
        ir = enc_i(6'b000100, 5'd0, 5'd0, 16'hFFEA);
        drive(1'b0, ir, 32'h100, 1'b0, 5'd0, 32'd0, mk(0, 0, 32'hFFFFFFEA, 0, 0, 0, 0, 0, 0));
        check("beq_neg_taken", 32'(branch), 32'd1);
        check("beq_neg_addr", branch_addr, 32'hA8);
        tick();

        // j 23 at PC 0x104.
        drive(1'b0, {6'b000010, 26'd23}, 32'h104, 1'b0, 5'd0, 32'd0, mk(0, 0, 23, 0, 0, 0, 0, 0, 0));
        check("j_jump", 32'(jump), 32'd1);
        check("j_addr", jump_addr, 32'h5C);
        check("j_nobranch", 32'(branch), 32'd0);
        tick();
        drive(1'b0, {6'b000010, 26'h3FFFFFF}, 32'hA000_0004, 1'b0, 5'd0, 32'd0,
              mk(31, 31, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0));
        check("j_addr_hi", jump_addr, 32'hAFFF_FFFC);
        tick();

        // reg9 <= 10, then sub $9,$9,$1 with same-cycle write 9 <= 7.
        drive(1'b0, 32'd0, 32'h0, 1'b1, 5'd9, 32'd10, ZERO);
        tick();
        ir = enc_r(5'd9, 5'd1, 5'd9, 6'b100010);
        drive(1'b0, ir, 32'h0, 1'b1, 5'd9, 32'd7, mk(7, 1, sx(ir), 9, 1, 1, 0, 0, 0));
        tick();

        // Remaining ALU ops and unsupported encodings.
        ir = enc_r(5'd5, 5'd6, 5'd4, 6'b100100);
        drive(1'b0, ir, 0, 0, 0, 0, mk(5, 6, sx(ir), 4, 2, 1, 0, 0, 0)); tick();
        ir = enc_r(5'd7, 5'd8, 5'd10, 6'b100101);
        drive(1'b0, ir, 0, 0, 0, 0, mk(7, 8, sx(ir), 10, 3, 1, 0, 0, 0)); tick();
        ir = enc_r(5'd11, 5'd12, 5'd13, 6'b101010);
        drive(1'b0, ir, 0, 0, 0, 0, mk(11, 12, sx(ir), 13, 4, 1, 0, 0, 0)); tick();
        ir = enc_r(5'd14, 5'd15, 5'd16, 6'b100001);
        drive(1'b0, ir, 0, 0, 0, 0, mk(14, 15, sx(ir), 0, 0, 0, 0, 0, 0)); tick();
        ir = enc_i(6'b001000, 5'd17, 5'd18, 16'h8001);
        drive(1'b0, ir, 0, 0, 0, 0, mk(17, 18, 32'hFFFF8001, 0, 0, 0, 0, 0, 0)); tick();

        // lw $3,0($0) and sw $9,2($0) (reg9 now 7).
        drive(1'b0, enc_i(6'b100011, 5'd0, 5'd3, 16'd0), 0, 0, 0, 0, mk(0, 3, 0, 3, 0, 1, 1, 0, 1));
        tick();
        drive(1'b0, enc_i(6'b101011, 5'd0, 5'd9, 16'd2), 0, 0, 0, 0, mk(0, 7, 2, 0, 0, 0, 0, 1, 1));
        tick();

        // Writes to $0 are neither bypassed nor stored.
        ir = enc_r(5'd0, 5'd0, 5'd1, 6'b100000);
        drive(1'b0, ir, 0, 1'b1, 5'd0, 32'hFFFF, mk(0, 0, sx(ir), 1, 0, 1, 0, 0, 0)); tick();
        drive(1'b0, ir, 0, 1'b0, 5'd0, 32'd0, mk(0, 0, sx(ir), 1, 0, 1, 0, 0, 0)); tick();

        // Mid-program reset with a write to $5 in flight; $5 and $9 restored.
        drive(1'b1, enc_i(6'b100011, 5'd9, 5'd3, 16'd4), 0, 1'b1, 5'd5, 32'h1234, ZERO);
        check("beq_in_rst", 32'(branch), 32'd0);
        tick();
        ir = enc_r(5'd5, 5'd9, 5'd2, 6'b100000);
        drive(1'b0, ir, 0, 0, 0, 0, mk(5, 9, sx(ir), 2, 0, 1, 0, 0, 0)); tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Absolute time bound so the run can never hang.
    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete, got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/instruction_decode.md
INSTRUCTION_DECODE -- requirements
Module: instruction_decode

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 IR  input  32  instruction word from fetch stage.
REQ-004 PC  input  32  fetch PC, equal to the IR instruction address + 4.
REQ-005 wb_en  input  1  write-back enable from write-back stage.
REQ-006 wb_addr  input  5  write-back destination register.
REQ-007 wb_data  input  32  write-back data.
REQ-008 jump  output  1  combinational; IR is j.
REQ-009 jump_addr  output  32  combinational; {PC[31:28], IR[25:0], 2'b00}.
REQ-010 branch  output  1  combinational; IR is beq and operands are equal.
REQ-011 branch_addr  output  32  combinational; PC + (sign-extended IR[15:0] << 2).
REQ-012 ex_rs_data, ex_rt_data  output  32 each  registered source operands.
REQ-013 ex_imm  output  32  registered sign-extended IR[15:0].
REQ-014 ex_dst  output  5  registered destination: rd for R-type, rt for lw.
REQ-015 ex_alu_op  output  3  registered: ADD=0, SUB=1, AND=2, OR=3, SLT=4.
REQ-016 ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src_imm  output  1 each  registered controls.

Function
REQ-017 Decoding: R-type (opcode 000000) with funct 100000/100010/100100/100101/101010 maps to ADD/SUB/AND/OR/SLT, reg_write=1.
REQ-018 lw (100011): ADD, alu_src_imm=1, mem_read=1, reg_write=1.
REQ-019 sw (101011): ADD, alu_src_imm=1, mem_write=1, rt data carried in ex_rt_data.
REQ-020 beq (000100) and j (000010): all ex_* controls 0; resolved in this stage only.
REQ-021 Any other opcode/funct: decoded as NOP; all ex_* controls 0, ex_dst=0.
REQ-022 Register file: 32x32; two combinational read ports (rs=IR[25:21], rt=IR[20:16]); one write port written at the edge when wb_en=1.
REQ-023 Register 0 reads 0; writes to register 0 are ignored.
REQ-024 Write-through bypass: if wb_en=1 and wb_addr equals a nonzero read address in the same cycle, the read returns wb_data; this applies to beq comparison and ex_* capture.
REQ-025 ID/EX latency: the ex_* outputs reflect the IR present before the edge, one cycle later; updated every cycle; no stall input.
REQ-026 branch and jump are never both 1; both are 0 while rst=1.
REQ-027 branch_addr uses 32-bit wrap-around addition; negative offsets are allowed (e.g., imm 0xFFEA -> PC-88).
REQ-028 The block inserts no flush; the program supplies delay-slot NOPs.

Reset
REQ-029 With rst=1 at an edge, all ex_* outputs become 0.
REQ-030 With rst=1 at an edge, register k is loaded with value k for k=0..31; rst overrides a simultaneous wb_en write.
REQ-031 Reset asserted mid-program takes effect at the next edge regardless of the IR in flight.

Structure
REQ-032 Package isa_pkg holds the opcode constants, the funct constants and the alu_op encoding.
REQ-033 Sub-module reg_file holds the register array, reset init, write port and bypass; instruction_decode holds the decoder, branch/jump resolution and ID/EX registers.

Verification
REQ-034 Reset, then read all registers via add rd,rs,$0 -> ex_rs_data=k for each k, ex_rt_data=0.
REQ-035 IR=beq $9,$2,+51, reg9=2, PC=0x44 -> branch=1, branch_addr=0x110; with reg9=3 -> branch=0.
REQ-036 IR=j 23, PC=0x104 -> jump=1, jump_addr=0x5C, branch=0, next ex_reg_write=0.
REQ-037 IR=sub $9,$9,$1 with reg9=10, plus wb_en=1, wb_addr=9, wb_data=7 in the same cycle -> next ex_rs_data=7, ex_rt_data=1, ex_alu_op=SUB, ex_dst=9.
REQ-038 IR=lw $3,0($0) -> ex_mem_read=1, ex_dst=3, ex_imm=0; IR=sw $9,2($0) -> ex_mem_write=1, ex_reg_write=0, ex_imm=2.
REQ-039 wb_en=1 to register 0 with data 0xFFFF then read $0 -> 0; rst asserted with wb_en=1, wb_addr=5 -> reg5=5 afterward.
